// File: rtl/io_pkg.sv
// io_pkg
// Shared definitions for the LSU memory-mapped I/O blocks:
//   - address windows for the output peripherals (LEDs, HEX, LCD) and the
//     input peripherals (switches, buttons)
//   - funct3 access-size encodings used by loads and stores
//   - LCD register bit positions and writable-bit mask
//   - LCD strobe sequencer state type
// No ports; imported by output_buffer and lcd_strobe_fsm.

package io_pkg;

   // Output peripheral windows (inclusive byte ranges)
   localparam logic [15:0] ADDR_LEDR_LO   = 16'h7000;
   localparam logic [15:0] ADDR_LEDR_HI   = 16'h700F;
   localparam logic [15:0] ADDR_LEDG_LO   = 16'h7010;
   localparam logic [15:0] ADDR_LEDG_HI   = 16'h701F;
   localparam logic [15:0] ADDR_HEXLO_LO  = 16'h7020;
   localparam logic [15:0] ADDR_HEXLO_HI  = 16'h7023;
   localparam logic [15:0] ADDR_HEXHI_LO  = 16'h7024;
   localparam logic [15:0] ADDR_HEXHI_HI  = 16'h7027;
   localparam logic [15:0] ADDR_LCD_LO    = 16'h7030;
   localparam logic [15:0] ADDR_LCD_HI    = 16'h703F;

   // Input peripheral windows, served by the load-side input path
   localparam logic [15:0] ADDR_SW_LO     = 16'h7800;
   localparam logic [15:0] ADDR_SW_HI     = 16'h780F;
   localparam logic [15:0] ADDR_KEY_LO    = 16'h7810;
   localparam logic [15:0] ADDR_KEY_HI    = 16'h781F;

   // Access sizes
   localparam logic [2:0] F3_BYTE = 3'b000;
   localparam logic [2:0] F3_HALF = 3'b001;
   localparam logic [2:0] F3_WORD = 3'b010;

   // LCD register layout
   localparam int LCD_RS_BIT   = 8;
   localparam int LCD_RW_BIT   = 9;
   localparam int LCD_BUSY_BIT = 30;
   localparam int LCD_ON_BIT   = 31;
   localparam logic [31:0] LCD_WR_MASK = 32'h8000_03FF;

   // HEX bytes keep only the seven segment bits
   localparam logic [31:0] HEX_WR_MASK = 32'h7F7F_7F7F;
   localparam logic [31:0] HEX_RESET   = 32'h7F7F_7F7F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2,
      HOLD  = 2'd3
   } lcd_state_e;

   function automatic logic in_range(input logic [15:0] addr,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
      return (addr >= lo) && (addr <= hi);
   endfunction

endpackage

// File: rtl/lcd_strobe_fsm.sv
// lcd_strobe_fsm
// Generates the character-LCD enable strobe: after a start request the bus
// fields are given P_SETUP cycles to settle, EN is high for P_PULSE cycles,
// then the fields are held for P_HOLD cycles before returning to idle.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   start - launch a sequence (only honoured when ready=1)
//   en    - registered LCD enable strobe, high only in PULSE
//   busy  - sequence in progress (state != IDLE)
//   ready - a start this cycle will be taken (idle, or final HOLD cycle)

module lcd_strobe_fsm
   import io_pkg::*;
#(
   parameter int P_SETUP = 2,
   parameter int P_PULSE = 12,
   parameter int P_HOLD  = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic en,
   output logic busy,
   output logic ready
);

   // Counter holds "cycles remaining after this one" in the current state
   localparam logic [15:0] SETUP_LOAD = 16'(P_SETUP - 1);
   localparam logic [15:0] PULSE_LOAD = 16'(P_PULSE - 1);
   localparam logic [15:0] HOLD_LOAD  = 16'(P_HOLD - 1);

   lcd_state_e  state_q, state_d;
   logic [15:0] count_q, count_d;
   logic        en_q;

   logic last_cycle;
   assign last_cycle = (count_q == 16'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= 16'd0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         en_q    <= (state_d == PULSE);
      end
   end

   // The last HOLD cycle may chain straight into a new SETUP, so a store
   // landing on the cycle busy drops is not lost.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETUP;
               count_d = SETUP_LOAD;
            end
         end
         SETUP: begin
            if (last_cycle) begin
               state_d = PULSE;
               count_d = PULSE_LOAD;
            end else begin
               count_d = count_q - 16'd1;
            end
         end
         PULSE: begin
            if (last_cycle) begin
               state_d = HOLD;
               count_d = HOLD_LOAD;
            end else begin
               count_d = count_q - 16'd1;
            end
         end
         HOLD: begin
            if (last_cycle) begin
               if (start) begin
                  state_d = SETUP;
                  count_d = SETUP_LOAD;
               end else begin
                  state_d = IDLE;
                  count_d = 16'd0;
               end
            end else begin
               count_d = count_q - 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = 16'd0;
         end
      endcase
   end

   assign en    = en_q;
   assign busy  = (state_q != IDLE);
   assign ready = (state_q == IDLE) || ((state_q == HOLD) && last_cycle);

endmodule

// File: rtl/output_buffer.sv
// output_buffer
// Store-side memory-mapped output peripherals of the LSU: red/green LED
// registers, eight 7-segment digits and a character-LCD port. Accepts
// byte/half/word stores and returns register contents combinationally.
// Ports:
//   i_clk, i_rst            - clock, synchronous active-high reset
//   i_addr                  - LSU byte address
//   i_st_en                 - one-cycle store strobe
//   i_funct3                - access size (byte/half/word)
//   i_st_data               - right-aligned store data
//   o_ld_data               - readback of the addressed register
//   o_io_ledr, o_io_ledg    - LED registers
//   o_io_hex0..o_io_hex7    - active-low segment patterns
//   o_lcd_data/rs/rw/en/on  - LCD bus, control strobes and power

module output_buffer
   import io_pkg::*;
#(
   parameter int P_LCD_SETUP = 2,
   parameter int P_LCD_PULSE = 12,
   parameter int P_LCD_HOLD  = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_addr,
   input  logic        i_st_en,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_st_data,
   output logic [31:0] o_ld_data,
   output logic [31:0] o_io_ledr,
   output logic [31:0] o_io_ledg,
   output logic [6:0]  o_io_hex0,
   output logic [6:0]  o_io_hex1,
   output logic [6:0]  o_io_hex2,
   output logic [6:0]  o_io_hex3,
   output logic [6:0]  o_io_hex4,
   output logic [6:0]  o_io_hex5,
   output logic [6:0]  o_io_hex6,
   output logic [6:0]  o_io_hex7,
   output logic [7:0]  o_lcd_data,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic        o_lcd_en,
   output logic        o_lcd_on
);

   // Places the store data into the lanes selected by size and offset;
   // lanes not touched keep the current register contents.
   function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                               input logic [31:0] data,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  offset);
      logic [31:0] res;
      res = cur;
      case (funct3)
         F3_BYTE: res[{offset, 3'b000} +: 8]        = data[7:0];
         F3_HALF: res[{offset[1], 4'b0000} +: 16]   = data[15:0];
         F3_WORD: res                               = data;
         default: res                               = cur;
      endcase
      return res;
   endfunction

   logic [31:0] ledr_q, ledg_q, hex_lo_q, hex_hi_q, lcd_q;
   logic        sel_ledr, sel_ledg, sel_hex_lo, sel_hex_hi, sel_lcd;
   logic        access_ok, store_ok, lcd_start;
   logic        lcd_en, lcd_busy, lcd_ready;
   logic [31:0] merged_ledr, merged_ledg, merged_hex_lo, merged_hex_hi, merged_lcd;

   assign sel_ledr   = in_range(i_addr, ADDR_LEDR_LO,  ADDR_LEDR_HI);
   assign sel_ledg   = in_range(i_addr, ADDR_LEDG_LO,  ADDR_LEDG_HI);
   assign sel_hex_lo = in_range(i_addr, ADDR_HEXLO_LO, ADDR_HEXLO_HI);
   assign sel_hex_hi = in_range(i_addr, ADDR_HEXHI_LO, ADDR_HEXHI_HI);
   assign sel_lcd    = in_range(i_addr, ADDR_LCD_LO,   ADDR_LCD_HI);

   // Misaligned halves/words and unknown sizes are dropped outright
   always_comb begin
      access_ok = 1'b0;
      case (i_funct3)
         F3_BYTE: access_ok = 1'b1;
         F3_HALF: access_ok = ~i_addr[0];
         F3_WORD: access_ok = (i_addr[1:0] == 2'b00);
         default: access_ok = 1'b0;
      endcase
   end

   assign store_ok  = i_st_en && access_ok;
   assign lcd_start = store_ok && sel_lcd && lcd_ready;

   assign merged_ledr   = merge_lanes(ledr_q,   i_st_data, i_funct3, i_addr[1:0]);
   assign merged_ledg   = merge_lanes(ledg_q,   i_st_data, i_funct3, i_addr[1:0]);
   assign merged_hex_lo = merge_lanes(hex_lo_q, i_st_data, i_funct3, i_addr[1:0]);
   assign merged_hex_hi = merge_lanes(hex_hi_q, i_st_data, i_funct3, i_addr[1:0]);
   assign merged_lcd    = merge_lanes(lcd_q,    i_st_data, i_funct3, i_addr[1:0]);

   // HEX bit 7 and unused LCD bits are never stored, so readback shows 0
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ledr_q   <= 32'd0;
         ledg_q   <= 32'd0;
         hex_lo_q <= HEX_RESET;
         hex_hi_q <= HEX_RESET;
         lcd_q    <= 32'd0;
      end else begin
         if (store_ok && sel_ledr)   ledr_q   <= merged_ledr;
         if (store_ok && sel_ledg)   ledg_q   <= merged_ledg;
         if (store_ok && sel_hex_lo) hex_lo_q <= merged_hex_lo & HEX_WR_MASK;
         if (store_ok && sel_hex_hi) hex_hi_q <= merged_hex_hi & HEX_WR_MASK;
         if (lcd_start)              lcd_q    <= merged_lcd & LCD_WR_MASK;
      end
   end

   lcd_strobe_fsm #(
      .P_SETUP (P_LCD_SETUP),
      .P_PULSE (P_LCD_PULSE),
      .P_HOLD  (P_LCD_HOLD)
   ) u_lcd_fsm (
      .clk   (i_clk),
      .rst   (i_rst),
      .start (lcd_start),
      .en    (lcd_en),
      .busy  (lcd_busy),
      .ready (lcd_ready)
   );

   // Readback ignores i_st_en; the LCD word carries the live busy flag
   always_comb begin
      o_ld_data = 32'd0;
      if (sel_ledr) begin
         o_ld_data = ledr_q;
      end else if (sel_ledg) begin
         o_ld_data = ledg_q;
      end else if (sel_hex_lo) begin
         o_ld_data = hex_lo_q;
      end else if (sel_hex_hi) begin
         o_ld_data = hex_hi_q;
      end else if (sel_lcd) begin
         o_ld_data               = lcd_q & LCD_WR_MASK;
         o_ld_data[LCD_BUSY_BIT] = lcd_busy;
      end
   end

   assign o_io_ledr  = ledr_q;
   assign o_io_ledg  = ledg_q;
   assign o_io_hex0  = hex_lo_q[6:0];
   assign o_io_hex1  = hex_lo_q[14:8];
   assign o_io_hex2  = hex_lo_q[22:16];
   assign o_io_hex3  = hex_lo_q[30:24];
   assign o_io_hex4  = hex_hi_q[6:0];
   assign o_io_hex5  = hex_hi_q[14:8];
   assign o_io_hex6  = hex_hi_q[22:16];
   assign o_io_hex7  = hex_hi_q[30:24];
   assign o_lcd_data = lcd_q[7:0];
   assign o_lcd_rs   = lcd_q[LCD_RS_BIT];
   assign o_lcd_rw   = lcd_q[LCD_RW_BIT];
   assign o_lcd_on   = lcd_q[LCD_ON_BIT];
   assign o_lcd_en   = lcd_en;

endmodule

// File: tb/tb_output_buffer.sv
// tb_output_buffer
// Directed self-checking bench for output_buffer: LED lane merging, HEX
// masking, address aliasing/unmapped reads and the LCD strobe timing,
// including dropped/accepted stores around busy and reset mid-pulse.

module tb_output_buffer;

   logic        clk;
   logic        rst;
   logic [15:0] addr;
   logic        st_en;
   logic [2:0]  funct3;
   logic [31:0] st_data;
   logic [31:0] ld_data;
   logic [31:0] ledr, ledg;
   logic [6:0]  hex [8];
   logic [7:0]  lcd_data;
   logic        lcd_rs, lcd_rw, lcd_en, lcd_on;

   int n_cmp = 0;
   int n_err = 0;

   output_buffer dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_addr    (addr),
      .i_st_en   (st_en),
      .i_funct3  (funct3),
      .i_st_data (st_data),
      .o_ld_data (ld_data),
      .o_io_ledr (ledr),
      .o_io_ledg (ledg),
      .o_io_hex0 (hex[0]),
      .o_io_hex1 (hex[1]),
      .o_io_hex2 (hex[2]),
      .o_io_hex3 (hex[3]),
      .o_io_hex4 (hex[4]),
      .o_io_hex5 (hex[5]),
      .o_io_hex6 (hex[6]),
      .o_io_hex7 (hex[7]),
      .o_lcd_data(lcd_data),
      .o_lcd_rs  (lcd_rs),
      .o_lcd_rw  (lcd_rw),
      .o_lcd_en  (lcd_en),
      .o_lcd_on  (lcd_on)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One store: driven mid-cycle, taken at the next rising edge
   task automatic applyStimulus(input logic [15:0] a, input logic [2:0] f3,
                                input logic [31:0] d);
      @(negedge clk);
      addr    = a;
      funct3  = f3;
      st_data = d;
      st_en   = 1'b1;
      @(posedge clk);
      #1 st_en = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic readAt(input logic [15:0] a);
      @(negedge clk);
      addr = a;
      #1;
   endtask

   // Called right after an accepted LCD store; walks cycles 1..17
   task automatic checkLcdSequence(input string tag);
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         checkOutput($sformatf("%s_en_c%0d", tag, k), 32'(lcd_en),
                     32'((k >= 3) && (k <= 14)));
         checkOutput($sformatf("%s_busy_c%0d", tag, k), 32'(ld_data[30]),
                     32'(k <= 16));
      end
   endtask

   initial begin
      rst = 1'b1; addr = 16'h7000; st_en = 1'b0; funct3 = 3'b010; st_data = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      readAt(16'h7000); checkOutput("rst_rd_ledr", ld_data, 32'h0);
      readAt(16'h7020); checkOutput("rst_rd_hexlo", ld_data, 32'h7F7F7F7F);
      readAt(16'h7030); checkOutput("rst_rd_lcd", ld_data, 32'h0);
      checkOutput("rst_ledr", ledr, 32'h0);
      checkOutput("rst_ledg", ledg, 32'h0);
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("rst_hex%0d", i), 32'(hex[i]), 32'h7F);
      checkOutput("rst_lcd_en", 32'(lcd_en), 32'h0);

      // LED lane merging, aliasing and dropped stores
      applyStimulus(16'h7000, 3'b010, 32'hDEADBEEF);
      applyStimulus(16'h7012, 3'b000, 32'h00000012);
      applyStimulus(16'h7002, 3'b001, 32'h0000ABCD);
      #1;
      checkOutput("ledr_merge", ledr, 32'hABCDBEEF);
      checkOutput("ledg_byte", ledg, 32'h00120000);
      applyStimulus(16'h7001, 3'b001, 32'h00005555);
      #1 checkOutput("ledr_mis_half", ledr, 32'hABCDBEEF);
      applyStimulus(16'h7002, 3'b010, 32'h11111111);
      #1 checkOutput("ledr_mis_word", ledr, 32'hABCDBEEF);
      applyStimulus(16'h7000, 3'b011, 32'h22222222);
      #1 checkOutput("ledr_bad_f3", ledr, 32'hABCDBEEF);
      applyStimulus(16'h7028, 3'b010, 32'h33333333);
      #1 checkOutput("ledr_unmapped", ledr, 32'hABCDBEEF);
      readAt(16'h700C); checkOutput("rd_ledr_alias", ld_data, 32'hABCDBEEF);
      readAt(16'h7028); checkOutput("rd_unmapped", ld_data, 32'h0);
      readAt(16'h701F); checkOutput("rd_ledg_top", ld_data, 32'h00120000);

      // HEX: bit 7 never stored
      applyStimulus(16'h7024, 3'b010, 32'hFFFF8040);
      #1;
      checkOutput("hex4", 32'(hex[4]), 32'h40);
      checkOutput("hex5", 32'(hex[5]), 32'h00);
      checkOutput("hex6", 32'(hex[6]), 32'h7F);
      checkOutput("hex7", 32'(hex[7]), 32'h7F);
      readAt(16'h7024); checkOutput("rd_hexhi", ld_data, 32'h7F7F0040);
      applyStimulus(16'h7023, 3'b000, 32'h00000005);
      #1 checkOutput("hex3_byte", 32'(hex[3]), 32'h05);
      readAt(16'h7020); checkOutput("rd_hexlo", ld_data, 32'h057F7F7F);

      // LCD sequence timing and fields
      applyStimulus(16'h7030, 3'b010, 32'h800001A5);
      checkLcdSequence("lcd1");
      checkOutput("lcd1_data", 32'(lcd_data), 32'hA5);
      checkOutput("lcd1_rs", 32'(lcd_rs), 32'h1);
      checkOutput("lcd1_rw", 32'(lcd_rw), 32'h0);
      checkOutput("lcd1_on", 32'(lcd_on), 32'h1);
      checkOutput("lcd1_rd", ld_data, 32'h800001A5);

      // Store at cycle 5 dropped, store at cycle 16 accepted
      applyStimulus(16'h7030, 3'b010, 32'h800001A5);
      repeat (4) @(posedge clk);
      applyStimulus(16'h7030, 3'b010, 32'h00000033);
      @(negedge clk);
      checkOutput("drop_data", 32'(lcd_data), 32'hA5);
      checkOutput("drop_rd", ld_data, 32'hC00001A5);
      repeat (10) @(posedge clk);
      applyStimulus(16'h7030, 3'b010, 32'h00000033);
      @(negedge clk);
      checkOutput("acc_data", 32'(lcd_data), 32'h33);
      checkOutput("acc_rs", 32'(lcd_rs), 32'h0);
      checkOutput("acc_on", 32'(lcd_on), 32'h0);
      checkOutput("acc_busy", 32'(ld_data[30]), 32'h1);
      checkOutput("acc_en_c1", 32'(lcd_en), 32'h0);
      repeat (2) @(negedge clk);
      checkOutput("acc_en_c3", 32'(lcd_en), 32'h1);

      // Reset in the middle of PULSE
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_en", 32'(lcd_en), 32'h0);
      checkOutput("mid_rst_rd", ld_data, 32'h0);
      checkOutput("mid_rst_data", 32'(lcd_data), 32'h0);
      checkOutput("mid_rst_ledr", ledr, 32'h0);
      checkOutput("mid_rst_hex4", 32'(hex[4]), 32'h7F);
      applyStimulus(16'h7030, 3'b010, 32'h80000142);
      checkLcdSequence("lcd2");
      checkOutput("lcd2_data", 32'(lcd_data), 32'h42);
      checkOutput("lcd2_rs", 32'(lcd_rs), 32'h1);
      checkOutput("lcd2_on", 32'(lcd_on), 32'h1);

      // Byte store to the RW lane alone still launches a sequence
      applyStimulus(16'h7031, 3'b000, 32'h00000002);
      @(negedge clk);
      checkOutput("rw_byte", 32'(lcd_rw), 32'h1);
      checkOutput("rw_busy", ld_data, 32'hC0000242);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
